// File: rtl/adc_pattern_gen_pkg.sv
// rtl/adc_pattern_gen_pkg.sv - shared encodings and PRBS9 helper for the ADC pattern generator
package adc_pattern_gen_pkg;

  localparam logic [1:0] MODE_ZERO  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_PRBS9 = 2'd3;

  localparam logic [8:0] PRBS9_SEED = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } gen_state_t;

  // x^9 + x^5 + 1, advanced n steps
  function automatic logic [8:0] prbs9_step(input logic [8:0] s, input int unsigned n);
    logic [8:0] r;
    r = s;
    for (int unsigned k = 0; k < n; k++) begin
      r = {r[7:0], r[8] ^ r[4]};
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_pattern_gen_prbs9_adv.sv
// rtl/adc_pattern_gen_prbs9_adv.sv - expands one PRBS9 state into NLANE consecutive lane samples
module adc_pattern_gen_prbs9_adv
  import adc_pattern_gen_pkg::*;
#(
  parameter int NLANE = 96,
  parameter int DW    = 9
) (
  input  logic [8:0]          state,
  output logic [NLANE*DW-1:0] lanes,
  output logic [8:0]          next_state
);

  logic [8:0] s;

  always_comb begin
    s     = state;
    lanes = '0;
    for (int i = 0; i < NLANE; i++) begin
      lanes[i*DW +: DW] = DW'(s);
      s = prbs9_step(s, 1);
    end
    next_state = s;
  end

endmodule

// File: rtl/adc_pattern_gen.sv
// rtl/adc_pattern_gen.sv - synthetic multi-lane ADC sample source with zero/const/ramp/PRBS9 bursts
module adc_pattern_gen
  import adc_pattern_gen_pkg::*;
#(
  parameter int NLANE = 96,
  parameter int DW    = 9,
  parameter int LENW  = 16
) (
  input  logic                ADC_CLK500M,
  input  logic                RSTN,
  input  logic [1:0]          CFG_MODE,
  input  logic [DW-1:0]       CFG_CONST,
  input  logic [LENW-1:0]     CFG_LEN,
  input  logic                START,
  input  logic                STOP,
  output logic [NLANE*DW-1:0] ADC_DATA,
  output logic                ADC_VALID,
  output logic                FRAME_SYNC,
  output logic                BUSY,
  output logic                DONE
);

  gen_state_t      state;
  logic [1:0]      mode_q;
  logic [DW-1:0]   const_q;
  logic [DW-1:0]   base_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] cnt_q;
  logic [8:0]      lfsr_q;

  logic                accept;
  logic                last_word;
  logic [1:0]          mode_sel;
  logic [DW-1:0]       const_sel;
  logic [DW-1:0]       base_sel;
  logic [8:0]          lfsr_sel;
  logic [NLANE*DW-1:0] prbs_lanes;
  logic [8:0]          prbs_next;
  logic [NLANE*DW-1:0] word;

  // On the START cycle the first word is built from the live CFG inputs and fresh seeds,
  // so it can be registered in the same edge that latches the configuration.
  assign accept    = (state == ST_IDLE) && START;
  assign mode_sel  = accept ? CFG_MODE   : mode_q;
  assign const_sel = accept ? CFG_CONST  : const_q;
  assign base_sel  = accept ? '0         : base_q;
  assign lfsr_sel  = accept ? PRBS9_SEED : lfsr_q;

  // cnt_q counts words already made visible, so equality means the last one is on the bus
  assign last_word = STOP || ((len_q != '0) && (cnt_q == len_q));

  adc_pattern_gen_prbs9_adv #(
    .NLANE (NLANE),
    .DW    (DW)
  ) u_prbs9_adv (
    .state      (lfsr_sel),
    .lanes      (prbs_lanes),
    .next_state (prbs_next)
  );

  always_comb begin
    word = '0;
    case (mode_sel)
      MODE_CONST: begin
        for (int i = 0; i < NLANE; i++) begin
          word[i*DW +: DW] = const_sel;
        end
      end
      MODE_RAMP: begin
        for (int i = 0; i < NLANE; i++) begin
          word[i*DW +: DW] = base_sel + DW'(i);
        end
      end
      MODE_PRBS9: word = prbs_lanes;
      default:    word = '0;
    endcase
  end

  always_ff @(posedge ADC_CLK500M) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_ZERO;
      const_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      lfsr_q     <= PRBS9_SEED;
      ADC_DATA   <= '0;
      ADC_VALID  <= 1'b0;
      FRAME_SYNC <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      ADC_DATA   <= '0;
      ADC_VALID  <= 1'b0;
      FRAME_SYNC <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            mode_q     <= CFG_MODE;
            const_q    <= CFG_CONST;
            len_q      <= CFG_LEN;
            cnt_q      <= LENW'(1);
            base_q     <= base_sel + DW'(NLANE);
            lfsr_q     <= prbs_next;
            ADC_DATA   <= word;
            ADC_VALID  <= 1'b1;
            FRAME_SYNC <= 1'b1;
            BUSY       <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_word) begin
            DONE  <= 1'b1;
            state <= ST_FIN;
          end else begin
            cnt_q     <= cnt_q + LENW'(1);
            base_q    <= base_sel + DW'(NLANE);
            lfsr_q    <= prbs_next;
            ADC_DATA  <= word;
            ADC_VALID <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// tb/tb_adc_pattern_gen.sv - self-checking bench for adc_pattern_gen against a sample-stream model
module tb_adc_pattern_gen;

  localparam int NLANE = 96;
  localparam int DW    = 9;
  localparam int LENW  = 16;
  localparam int MAXW  = 64;

  logic                clk = 1'b0;
  logic                rstn;
  logic [1:0]          cfg_mode;
  logic [DW-1:0]       cfg_const;
  logic [LENW-1:0]     cfg_len;
  logic                start;
  logic                stop;
  logic [NLANE*DW-1:0] adc_data;
  logic                adc_valid;
  logic                frame_sync;
  logic                busy;
  logic                done;

  int errors = 0;
  int checks = 0;

  logic [8:0]    prbs_ref [0:MAXW*NLANE-1];
  logic [DW-1:0] cap      [0:MAXW*NLANE-1];

  always #5 clk = ~clk;

  adc_pattern_gen #(.NLANE(NLANE), .DW(DW), .LENW(LENW)) dut (
    .ADC_CLK500M (clk),
    .RSTN        (rstn),
    .CFG_MODE    (cfg_mode),
    .CFG_CONST   (cfg_const),
    .CFG_LEN     (cfg_len),
    .START       (start),
    .STOP        (stop),
    .ADC_DATA    (adc_data),
    .ADC_VALID   (adc_valid),
    .FRAME_SYNC  (frame_sync),
    .BUSY        (busy),
    .DONE        (done)
  );

  // Sample k of the deinterleaved stream of a burst (k = word*NLANE + lane)
  function automatic logic [DW-1:0] exp_sample(input int mode, input logic [DW-1:0] c, input int k);
    case (mode)
      0:       return '0;
      1:       return c;
      2:       return DW'(k % 512);
      default: return DW'(prbs_ref[k]);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_word(input string tag, input int mode, input logic [DW-1:0] c, input int w);
    int bad;
    logic [DW-1:0] bad_o;
    logic [DW-1:0] bad_e;
    bad = -1;
    bad_o = '0;
    bad_e = '0;
    for (int i = 0; i < NLANE; i++) begin
      logic [DW-1:0] o;
      logic [DW-1:0] e;
      o = adc_data[i*DW +: DW];
      e = exp_sample(mode, c, w*NLANE + i);
      cap[w*NLANE + i] = o;
      if (o !== e && bad < 0) begin
        bad = i;
        bad_o = o;
        bad_e = e;
      end
    end
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("FAIL %s word=%0d lane=%0d observed=%0h expected=%0h", tag, w, bad, bad_o, bad_e);
    end
  endtask

  // One burst: checks every visible word, then the DONE cycle and the return to idle.
  // stop_at = 1-based word during which STOP is raised (0 = never).
  task automatic run_burst(input int mode, input logic [DW-1:0] c, input int len,
                           input int stop_at, input bit pulses);
    int nwords;
    if (len == 0) nwords = stop_at;
    else if (stop_at != 0 && stop_at < len) nwords = stop_at;
    else nwords = len;
    cfg_mode  = 2'(mode);
    cfg_const = c;
    cfg_len   = LENW'(len);
    start     = 1'b1;
    stop      = 1'b0;
    tick;
    start     = 1'b0;
    cfg_mode  = 2'($urandom);
    cfg_const = DW'($urandom);
    cfg_len   = LENW'($urandom_range(0, 3));
    for (int w = 0; w < nwords; w++) begin
      chk("valid", 64'(adc_valid), 64'd1);
      chk("frame_sync", 64'(frame_sync), 64'(w == 0));
      chk("busy", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      chk_word("data", mode, c, w);
      stop  = (stop_at == w + 1);
      start = (pulses && (w + 1 < nwords)) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
    end
    start = 1'b0;
    chk("valid_fin", 64'(adc_valid), 64'd0);
    chk("busy_fin", 64'(busy), 64'd0);
    chk("done_fin", 64'(done), 64'd1);
    chk("frame_sync_fin", 64'(frame_sync), 64'd0);
    chk("data_fin_zero", 64'(|adc_data), 64'd0);
    stop = 1'b0;
    tick;
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("valid_idle", 64'(adc_valid), 64'd0);
  endtask

  initial begin
    logic [8:0] s;
    int mism;
    int rmode;
    int rlen;
    int rstop;
    logic [DW-1:0] rc;

    s = 9'h1FF;
    for (int k = 0; k < MAXW*NLANE; k++) begin
      prbs_ref[k] = s;
      s = {s[7:0], s[8] ^ s[4]};
    end

    rstn = 1'b0; cfg_mode = '0; cfg_const = '0; cfg_len = '0; start = 1'b0; stop = 1'b0;
    tick;
    tick;
    chk("rst_valid", 64'(adc_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_frame_sync", 64'(frame_sync), 64'd0);
    chk("rst_data", 64'(|adc_data), 64'd0);
    rstn = 1'b1;
    tick;

    // ramp LEN=7 with wrap
    run_burst(2, '0, 7, 0, 1'b1);
    chk("ramp_w0_l0", 64'(cap[0]), 64'd0);
    chk("ramp_w0_l95", 64'(cap[95]), 64'd95);
    chk("ramp_w1_l0", 64'(cap[96]), 64'd96);
    chk("ramp_w3_l95", 64'(cap[3*96+95]), 64'd383);
    chk("ramp_w5_l40", 64'(cap[5*96+40]), 64'd8);
    chk("ramp_w6_l0", 64'(cap[6*96]), 64'd64);

    // single-word constant burst
    run_burst(1, 9'h1A5, 1, 0, 1'b0);
    chk("const_l50", 64'(cap[50]), 64'h1A5);

    // PRBS9 16 words
    run_burst(3, DW'($urandom), 16, 0, 1'b1);
    chk("prbs_w0_l0", 64'(cap[0]), 64'h1FF);
    chk("prbs_w0_l1", 64'(cap[1]), 64'h1FE);
    mism = 0;
    for (int k = 0; k + 511 < 16*NLANE; k++) begin
      if (cap[k] !== cap[k+511]) mism++;
    end
    chk("prbs_period_511", 64'(mism), 64'd0);

    // continuous, STOP during the 10th word, START pulses while busy
    run_burst(2, '0, 0, 10, 1'b1);

    // STOP landing on the final word of a length-limited burst
    run_burst(1, DW'($urandom), 5, 5, 1'b0);

    // START and STOP together in idle
    cfg_mode = 2'd2; cfg_len = '0; start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0;
    chk("ss_valid", 64'(adc_valid), 64'd1);
    chk("ss_frame_sync", 64'(frame_sync), 64'd1);
    tick;
    chk("ss_valid_end", 64'(adc_valid), 64'd0);
    chk("ss_done", 64'(done), 64'd1);
    stop = 1'b0;
    tick;
    chk("ss_done_once", 64'(done), 64'd0);

    // randomized bursts
    repeat (8) begin
      rmode = int'($urandom_range(0, 3));
      rc    = DW'($urandom);
      rlen  = int'($urandom_range(0, 20));
      if (rlen == 0) rstop = int'($urandom_range(1, 20));
      else rstop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rlen)) : 0;
      run_burst(rmode, rc, rlen, rstop, 1'b1);
    end

    // mid-burst reset
    cfg_mode = 2'd2; cfg_len = '0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    tick;
    chk("mid_rst_valid", 64'(adc_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", 64'(|adc_data), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    tick;
    chk("mid_rst_done2", 64'(done), 64'd0);
    tick;
    rstn = 1'b1;
    tick;
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_valid", 64'(adc_valid), 64'd0);
    run_burst(2, '0, 3, 0, 1'b0);
    chk("post_rst_ramp_l0", 64'(cap[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
